// File: rtl/microwave_ctrl.sv
// Microwave oven control FSM: start/pause/cancel buttons, door interlock,
// countdown-timer handshake and an optional completion tone.
// Optional feature macro: DONE_BEEP_EN (completion beep with 8-bit down counter).
module microwave_ctrl #(
  parameter int BEEP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       cancel_n,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       timer_en,
  output logic       timer_clrn,
  output logic       mag_on,
  output logic [1:0] state,
  output logic       beep
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COOK  = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Counter load value: the entry cycle counts as the first beep cycle.
  localparam logic [7:0] BEEP_LOAD = 8'(BEEP_CYCLES - 1);

  state_t state_reg, state_next;
  logic   start_prev_reg, stop_prev_reg;
  logic   armed_reg;        // low until the first edge after reset release
  logic   timer_en_reg, timer_clrn_reg;
  logic   start_ev, stop_ev;

  // Falling-edge detection on the buttons; suppressed on the first edge after
  // reset so a button already held at release does not count as a press.
  assign start_ev = armed_reg & start_prev_reg & ~startn;
  assign stop_ev  = armed_reg & stop_prev_reg  & ~stopn;

  // State, button history and registered timer controls.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg      <= IDLE;
      start_prev_reg <= 1'b1;
      stop_prev_reg  <= 1'b1;
      armed_reg      <= 1'b0;
      timer_en_reg   <= 1'b0;
      timer_clrn_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      start_prev_reg <= startn;
      stop_prev_reg  <= stopn;
      armed_reg      <= 1'b1;
      timer_en_reg   <= (state_next == COOK);
      timer_clrn_reg <= cancel_n;
    end
  end

  // Next-state logic; cancel overrides everything, timer_zero beats stop/door.
  always_comb begin
    state_next = state_reg;
    if (!cancel_n) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_ev && door_closed && !timer_zero) state_next = COOK;
        end
        COOK: begin
          if (timer_zero)                   state_next = DONE;
          else if (stop_ev || !door_closed) state_next = PAUSE;
        end
        PAUSE: begin
          if (start_ev && door_closed && !timer_zero) state_next = COOK;
        end
        DONE: begin
          if (!door_closed) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign state      = state_reg;
  assign timer_en   = timer_en_reg;
  assign timer_clrn = timer_clrn_reg;
  // Door opening cuts the magnetron within the same cycle.
  assign mag_on     = (state_reg == COOK) & door_closed;

`ifdef DONE_BEEP_EN
  logic [7:0] beep_cnt_reg;
  logic       beep_reg;

  // Beep for BEEP_CYCLES cycles from DONE entry; any exit clears it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      beep_reg     <= 1'b0;
      beep_cnt_reg <= 8'd0;
    end else if (state_next != DONE) begin
      beep_reg     <= 1'b0;
      beep_cnt_reg <= 8'd0;
    end else if (state_reg != DONE) begin
      beep_reg     <= 1'b1;
      beep_cnt_reg <= BEEP_LOAD;
    end else if (beep_cnt_reg != 8'd0) begin
      beep_cnt_reg <= beep_cnt_reg - 8'd1;
    end else begin
      beep_reg <= 1'b0;
    end
  end

  assign beep = beep_reg;
`else
  // Tone feature absent: the length parameter has no effect.
  logic unused_beep_cfg;
  assign unused_beep_cfg = ^BEEP_LOAD;
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed testbench for microwave_ctrl; one task per scenario.
module tb_microwave_ctrl;

`ifdef DONE_BEEP_EN
  localparam int EXP_BEEP = 8;
`else
  localparam int EXP_BEEP = 0;
`endif

  logic       clk = 1'b0;
  logic       clrn, startn, stopn, cancel_n, door_closed, timer_zero;
  logic       timer_en, timer_clrn, mag_on, beep;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  microwave_ctrl #(.BEEP_CYCLES(8)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .startn     (startn),
    .stopn      (stopn),
    .cancel_n   (cancel_n),
    .door_closed(door_closed),
    .timer_zero (timer_zero),
    .timer_en   (timer_en),
    .timer_clrn (timer_clrn),
    .mag_on     (mag_on),
    .state      (state),
    .beep       (beep)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_cook();
    startn = 1'b0; step();
    startn = 1'b1; step();
  endtask

  task automatic go_idle();
    cancel_n = 1'b0; step();
    cancel_n = 1'b1; step();
    timer_zero = 1'b0; door_closed = 1'b1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; startn = 1'b1; stopn = 1'b1; cancel_n = 1'b1;
    door_closed = 1'b1; timer_zero = 1'b0;
    step(2);
    total++;
    if ({state, timer_en, mag_on, timer_clrn, beep} !== 6'b00_0_0_1_0) begin
      bad++;
      $display("FAIL reset_outputs: got state=%b en=%b mag=%b clrn=%b beep=%b want 00 0 0 1 0",
               state, timer_en, mag_on, timer_clrn, beep);
    end
    clrn = 1'b1;
    step();
    total++;
    if (state !== 2'b00) begin
      bad++; $display("FAIL reset_release_state: got %b want 00", state);
    end
    $display("reset: state=%b timer_clrn=%b", state, timer_clrn);
  endtask

  task automatic test_cook_done();
    startn = 1'b0; step();
    total++;
    if ({state, timer_en, mag_on} !== 4'b01_1_1) begin
      bad++; $display("FAIL cook_start: got state=%b en=%b mag=%b want 01 1 1", state, timer_en, mag_on);
    end
    startn = 1'b1; step();
    timer_zero = 1'b1; step();
    total++;
    if ({state, timer_en, mag_on} !== 4'b11_0_0) begin
      bad++; $display("FAIL cook_done: got state=%b en=%b mag=%b want 11 0 0", state, timer_en, mag_on);
    end
    door_closed = 1'b0; step();
    total++;
    if (state !== 2'b00) begin
      bad++; $display("FAIL done_door_open: got state=%b want 00", state);
    end
    timer_zero = 1'b0; door_closed = 1'b1; step();
    $display("cook_done: final state=%b", state);
  endtask

  task automatic test_door_pause();
    start_cook();
    door_closed = 1'b0; #1;
    total++;
    if ({state, mag_on} !== 3'b01_0) begin
      bad++; $display("FAIL door_mag_same_cycle: got state=%b mag=%b want 01 0", state, mag_on);
    end
    step();
    total++;
    if ({state, timer_en} !== 3'b10_0) begin
      bad++; $display("FAIL door_pause: got state=%b en=%b want 10 0", state, timer_en);
    end
    start_cook();
    total++;
    if (state !== 2'b10) begin
      bad++; $display("FAIL start_door_open: got state=%b want 10", state);
    end
    door_closed = 1'b1; startn = 1'b0; step();
    total++;
    if ({state, mag_on} !== 3'b01_1) begin
      bad++; $display("FAIL resume: got state=%b mag=%b want 01 1", state, mag_on);
    end
    startn = 1'b1; step();
    go_idle();
    $display("door_pause: final state=%b", state);
  endtask

  task automatic test_held_buttons();
    int changes;
    logic [1:0] prev;
    changes = 0; prev = state;
    startn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (state !== prev) changes++;
      prev = state;
    end
    startn = 1'b1; step();
    total++;
    if (changes !== 1 || state !== 2'b01) begin
      bad++; $display("FAIL held_start: got changes=%0d state=%b want 1 01", changes, state);
    end
    changes = 0; prev = state;
    stopn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (state !== prev) changes++;
      prev = state;
    end
    stopn = 1'b1; step();
    total++;
    if (changes !== 1 || state !== 2'b10) begin
      bad++; $display("FAIL held_stop: got changes=%0d state=%b want 1 10", changes, state);
    end
    go_idle();
    $display("held_buttons: final state=%b", state);
  endtask

  task automatic test_cancel_priority();
    start_cook();
    cancel_n = 1'b0; stopn = 1'b0; step();
    total++;
    if ({state, timer_clrn} !== 3'b00_0) begin
      bad++; $display("FAIL cancel_vs_stop: got state=%b tclrn=%b want 00 0", state, timer_clrn);
    end
    cancel_n = 1'b1; stopn = 1'b1; step();
    total++;
    if ({state, timer_clrn} !== 3'b00_1) begin
      bad++; $display("FAIL cancel_pulse_end: got state=%b tclrn=%b want 00 1", state, timer_clrn);
    end
    cancel_n = 1'b0; step(3);
    total++;
    if (timer_clrn !== 1'b0) begin
      bad++; $display("FAIL cancel_held: got tclrn=%b want 0", timer_clrn);
    end
    cancel_n = 1'b1; step();
    total++;
    if (timer_clrn !== 1'b1) begin
      bad++; $display("FAIL cancel_release: got tclrn=%b want 1", timer_clrn);
    end
    $display("cancel_priority: state=%b", state);
  endtask

  task automatic test_beep();
    int cnt;
    start_cook();
    timer_zero = 1'b1; step();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (beep === 1'b1) cnt++;
      step();
    end
    total++;
    if (cnt !== EXP_BEEP || state !== 2'b11) begin
      bad++; $display("FAIL beep_length: got cycles=%0d state=%b want %0d 11", cnt, state, EXP_BEEP);
    end
    door_closed = 1'b0; step();
    timer_zero = 1'b0; door_closed = 1'b1; step();
    start_cook();
    timer_zero = 1'b1; step();
    step(2);
    total++;
    if (beep !== (EXP_BEEP > 0)) begin
      bad++; $display("FAIL beep_cycle3: got beep=%b want %b", beep, EXP_BEEP > 0);
    end
    door_closed = 1'b0; step();
    total++;
    if ({state, beep} !== 3'b00_0) begin
      bad++; $display("FAIL beep_abort: got state=%b beep=%b want 00 0", state, beep);
    end
    timer_zero = 1'b0; door_closed = 1'b1; step();
    $display("beep: counted %0d cycles", cnt);
  endtask

  task automatic test_reset_mid_cook();
    start_cook();
    #2 clrn = 1'b0; #1;
    total++;
    if ({state, timer_en, mag_on, timer_clrn} !== 5'b00_0_0_1) begin
      bad++; $display("FAIL async_reset: got state=%b en=%b mag=%b tclrn=%b want 00 0 0 1",
                      state, timer_en, mag_on, timer_clrn);
    end
    startn = 1'b0; step();
    clrn = 1'b1; step(4);
    total++;
    if ({state, mag_on} !== 3'b00_0) begin
      bad++; $display("FAIL held_through_release: got state=%b mag=%b want 00 0", state, mag_on);
    end
    startn = 1'b1; step();
    start_cook();
    total++;
    if (state !== 2'b01) begin
      bad++; $display("FAIL start_after_release: got state=%b want 01", state);
    end
    $display("reset_mid_cook: state=%b", state);
  endtask

  initial begin
    test_reset();
    test_cook_done();
    test_door_pause();
    test_held_buttons();
    test_cancel_priority();
    test_beep();
    test_reset_mid_cook();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microwave_ctrl.md
MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

Interface
REQ-001 SHALL have parameter BEEP_CYCLES, default 8, the number of clock cycles beep is held high on cook completion (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port startn  input  1  start button, active-low level, synchronous to clk.
REQ-005 SHALL have port stopn  input  1  pause button, active-low level, synchronous to clk.
REQ-006 SHALL have port cancel_n  input  1  clear/cancel button, active-low level, synchronous to clk.
REQ-007 SHALL have port door_closed  input  1  1 = door closed.
REQ-008 SHALL have port timer_zero  input  1  zero flag from the downstream countdown timer.
REQ-009 SHALL have port timer_en  output  1  count enable driven to the timer's en.
REQ-010 SHALL have port timer_clrn  output  1  active-low clear pulse driven to the timer.
REQ-011 SHALL have port mag_on  output  1  magnetron drive.
REQ-012 SHALL have port state  output  2  current state code.
REQ-013 SHALL have port beep  output  1  completion tone enable.

Function
REQ-014 SHALL register startn and stopn each cycle; start_ev = prev 1 and current 0; stop_ev likewise; held buttons produce one event only.
REQ-015 SHALL implement states IDLE=2'b00, COOK=2'b01, PAUSE=2'b10, DONE=2'b11, with state a registered output.
REQ-016 SHALL, in any state, go to IDLE when cancel_n=0 is sampled; cancel has priority over all other transitions.
REQ-017 SHALL drive timer_clrn=0 for exactly one cycle, the cycle after each cycle where cancel_n=0 is sampled, else 1; holding cancel_n low keeps timer_clrn low.
REQ-018 SHALL go IDLE->COOK on start_ev when door_closed=1 and timer_zero=0; otherwise IDLE is held.
REQ-019 SHALL go COOK->DONE when timer_zero=1; with timer_zero=0, COOK->PAUSE on stop_ev or door_closed=0; timer_zero has priority over stop/door.
REQ-020 SHALL go PAUSE->COOK on start_ev with door_closed=1 and timer_zero=0; start_ev with door open is discarded.
REQ-021 SHALL go DONE->IDLE when door_closed=0; start_ev and stop_ev in DONE are ignored.
REQ-022 SHALL drive timer_en=1 iff state==COOK (registered, no combinational input path).
REQ-023 SHALL drive mag_on = (state==COOK) AND door_closed, combinationally, so opening the door kills the magnetron in the same cycle.
REQ-024 SHALL ignore stop_ev in IDLE and PAUSE.

Reset
REQ-025 SHALL, while clrn=0, asynchronously force state=IDLE, timer_en=0, mag_on=0, timer_clrn=1, beep=0, button history registers=1, beep counter=0.
REQ-026 SHALL NOT generate start_ev/stop_ev in the first cycle after reset release if a button is already held.
REQ-027 SHALL abort cooking immediately on reset mid-COOK (mag_on=0 asynchronously).

Configuration
REQ-028 SHALL, with macro DONE_BEEP_EN defined, assert beep for exactly BEEP_CYCLES cycles starting the cycle state becomes DONE, using an 8-bit down counter; leaving DONE or cancel clears beep and counter the next edge.
REQ-029 SHALL, without DONE_BEEP_EN, tie beep to 0 and omit the counter; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: door_closed=1, timer_zero=0, startn pulse low -> state 01, timer_en=1, mag_on=1 next edge; timer_zero=1 -> state 11, timer_en=0, mag_on=0.
REQ-031 SHALL cover: in COOK, door_closed 1->0 -> mag_on=0 same cycle, state 10 next edge; startn pulse with door open -> stays 10; close door, startn pulse -> 01.
REQ-032 SHALL cover: startn held low 20 cycles from IDLE -> exactly one IDLE->COOK transition; stopn held low -> one COOK->PAUSE, no further change.
REQ-033 SHALL cover: cancel_n low one cycle in COOK with stopn pulse in same cycle -> state 00 (not 10), timer_clrn=0 for one cycle.
REQ-034 SHALL cover: DONE_BEEP_EN defined, BEEP_CYCLES=8, reach DONE -> beep high exactly 8 cycles; repeat with door opened at cycle 3 -> beep low at next edge, state 00.
REQ-035 SHALL cover: clrn asserted mid-COOK between clock edges -> mag_on, timer_en 0 immediately, state 00; startn held through release -> remains 00.
